test_bed: RTL and testbench
===========================

Name: test_bed

Overview:
- Self-checking result monitor placed beside the CHIP (RISC-V core plus I/D caches).
- Snoops every processor store presented to the D-cache and compares stores into a golden answer region against a constant table.
- Counts mismatches and measures the run length in cycles.
- Raises finish when the program writes an end marker, which lets the simulation stop.

Parameters:
- ANS_BASE, 30'd64: word address of answer[0]; byte address is ANS_BASE<<2.
- NUM_ANS, 16: number of golden answers; legal range 1..256.
- END_ADDR, 30'd255: word address whose write ends the run.

Ports:
- clk, input, 1: single system clock; all state updates on rising edge.
- rst, input, 1: reset, asynchronous, active-low (named rst as in the codebase).
- addr, input, 30: word address of the current D-cache access (byte address [31:2]).
- data, input, 32: store data of the current access.
- wen, input, 1: 1 means the current access is a store; sampled every rising edge.
- error_num, output, 8: count of mismatching answer stores.
- duration, output, 16: cycles spent in CHECK.
- finish, output, 1: run complete, held high.

Behaviour:
- Store event: wen==1 at a rising edge. Each cycle with wen high is one event; back-to-back events are all processed.
- Answer index: idx = addr-ANS_BASE. An address is "in region" iff ANS_BASE <= addr < ANS_BASE+NUM_ANS.
- State register curstate[1:0], hierarchically visible under that name: IDLE=2'b00, CHECK=2'b01, DONE=2'b10; 2'b11 is unreachable and recovers to IDLE.
- Reset (rst low, async): curstate=IDLE, error_num=0, duration=0, finish=0. Reset mid-run clears everything; the next run starts fresh.
- IDLE:
  - Go to CHECK only on a store with addr==ANS_BASE and data==golden[0].
  - All other stores are ignored, including a wrong answer[0], other region writes, and END_ADDR.
  - Staying in IDLE forever signals that the first answer is wrong.
- CHECK:
  - duration increments by 1 every cycle, saturating at 16'hFFFF. The transition edge into CHECK sets duration=1.
  - In-region store with data != golden[idx]: error_num += 1, saturating at 8'hFF.
  - In-region store with a match: no change.
  - Rewrites of the same index are each re-checked.
  - Stores outside the region and not to END_ADDR are ignored.
  - Store to END_ADDR: go to DONE. duration does not increment on that edge.
  - If END_ADDR lies inside the region, the end check takes priority and no compare is done for that store.
- DONE:
  - finish=1, registered: it rises the edge after the END_ADDR store is sampled.
  - error_num and duration are frozen.
  - Remains in DONE until reset; all stores are ignored.
- Outputs are direct register outputs; there is no combinational path from inputs to outputs.
- No storage of store data; the compare is a single-cycle lookup of golden[idx].

Decomposition:
- Package test_bed_pkg holds:
  - state encodings IDLE/CHECK/DONE;
  - default ANS_BASE, NUM_ANS, END_ADDR;
  - the golden table as a constant function golden(idx) returning 32 bits.
- Default table: golden(i) = 3*i+1 (i.e. 1, 4, 7, … 46). Program-specific tables replace only the package.
- No sub-module needed; a single module holding the FSM, counters and compare is natural.

Test Plan:
- Reset then store (64, 1): curstate 00→01, duration=1 next edge. Then store (255, x): finish=1 one edge later, error_num=0.
- Store (64, 5) first: curstate stays 00 indefinitely, finish=0. A later store (64, 1) moves to 01.
- In CHECK, store (65, 4), (66, 0), (79, 99), (70, 19): error_num=2 (entries 66 and 79 are wrong), then END → finish=1.
- Hold CHECK for 70000 cycles without END: duration saturates at 16'hFFFF. Issue 300 wrong stores: error_num=255.
- In DONE, more stores to the region and END: outputs unchanged. Pulse rst low mid-CHECK: all outputs 0 immediately (async), curstate=00.
- Stores with wen=0 to region and END addresses, in any state: no effect on any output.

Source files
------------

// File: rtl/test_bed_pkg.sv
// Shared constants for the result monitor: state encodings, default answer
// region layout and the golden answer table for the current program.
package test_bed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [29:0] ANS_BASE_DEF = 30'd64;
  localparam int          NUM_ANS_DEF  = 16;
  localparam logic [29:0] END_ADDR_DEF = 30'd255;

  // Program-specific tables replace only this function.
  function automatic logic [31:0] golden(input logic [7:0] idx);
    return 32'(idx) * 32'd3 + 32'd1;
  endfunction

endpackage

// File: rtl/test_bed.sv
// Result monitor beside the CHIP: snoops D-cache stores, checks the answer
// region against the golden table, counts errors and run length.
module test_bed
  import test_bed_pkg::*;
#(
  parameter logic [29:0] ANS_BASE = ANS_BASE_DEF,
  parameter int          NUM_ANS  = NUM_ANS_DEF,
  parameter logic [29:0] END_ADDR = END_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic [7:0]  error_num,
  output logic [15:0] duration,
  output logic        finish
);

  localparam logic [29:0] NUM_ANS_W = 30'(NUM_ANS);

  state_e      curstate, curstate_d;
  logic [7:0]  error_num_q, error_num_d;
  logic [15:0] duration_q, duration_d;
  logic        finish_q, finish_d;

  logic [29:0] off;
  logic        in_region;
  logic        ans_bad;

  always_comb begin
    off       = addr - ANS_BASE;
    in_region = (addr >= ANS_BASE) && (off < NUM_ANS_W);
    ans_bad   = data != golden(off[7:0]);
  end

  always_comb begin
    curstate_d  = curstate;
    error_num_d = error_num_q;
    duration_d  = duration_q;
    finish_d    = finish_q;
    case (curstate)
      IDLE: begin
        // Only a correct answer[0] starts the run.
        if (wen && addr == ANS_BASE && data == golden(8'd0)) begin
          curstate_d  = CHECK;
          duration_d  = 16'd1;
          error_num_d = 8'd0;
        end
      end
      CHECK: begin
        // End marker wins over the compare even when it sits in the region.
        if (wen && addr == END_ADDR) begin
          curstate_d = DONE;
          finish_d   = 1'b1;
        end else begin
          if (duration_q != 16'hFFFF) duration_d = duration_q + 16'd1;
          if (wen && in_region && ans_bad && error_num_q != 8'hFF)
            error_num_d = error_num_q + 8'd1;
        end
      end
      DONE: finish_d = 1'b1;
      default: curstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curstate    <= IDLE;
      error_num_q <= 8'd0;
      duration_q  <= 16'd0;
      finish_q    <= 1'b0;
    end else begin
      curstate    <= curstate_d;
      error_num_q <= error_num_d;
      duration_q  <= duration_d;
      finish_q    <= finish_d;
    end
  end

  assign error_num = error_num_q;
  assign duration  = duration_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_test_bed.sv
// Randomized bench for test_bed against a run-level reference model, plus
// directed scenarios with hand-computed expectations.
module tb_test_bed;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic        wen = 1'b0;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;

  test_bed dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .error_num(error_num), .duration(duration), .finish(finish)
  );

  always #5 clk = ~clk;

  localparam int BASE = 64;
  localparam int NANS = 16;
  localparam int ENDA = 255;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  // Reference model: the run is "started" by a correct answer[0] and "ended"
  // by the end marker; counters follow plain saturating arithmetic.
  bit started = 0, ended = 0;
  int m_err = 0, m_dur = 0;

  function automatic int gold(int i);
    return 3 * i + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      started = 0; ended = 0; m_err = 0; m_dur = 0;
    end else if (ended) begin
    end else if (!started) begin
      if (wen && int'(addr) == BASE && int'(data) == gold(0)) begin
        started = 1; m_dur = 1; m_err = 0;
      end
    end else if (wen && int'(addr) == ENDA) begin
      ended = 1;
    end else begin
      m_dur = (m_dur + 1 > 65535) ? 65535 : m_dur + 1;
      if (wen && int'(addr) >= BASE && int'(addr) < BASE + NANS &&
          data != 32'(gold(int'(addr) - BASE)))
        m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_state", 32'(dut.curstate), ended ? 32'd2 : (started ? 32'd1 : 32'd0));
      check("m_error_num", 32'(error_num), 32'(m_err));
      check("m_duration", 32'(duration), 32'(m_dur));
      check("m_finish", 32'(finish), 32'(ended));
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic drive(bit w, int a, int d);
    wen = w; addr = 30'(a); data = 32'(d);
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, $urandom_range(0, 300), $urandom);
  endtask

  // Async reset pulse taken between edges; outputs must clear at once.
  task automatic pulse_reset(bit chk);
    #2 rst = 1'b0;
    #1;
    if (chk) begin
      check("rst_state", 32'(dut.curstate), 32'd0);
      check("rst_error_num", 32'(error_num), 32'd0);
      check("rst_duration", 32'(duration), 32'd0);
      check("rst_finish", 32'(finish), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1;
    check("reset_state", 32'(dut.curstate), 32'd0);
    check("reset_outputs", {error_num, duration, 7'd0, finish}, 32'd0);

    // Basic start / end.
    drive(1, 64, 1);
    check("start_state", 32'(dut.curstate), 32'd1);
    check("start_duration", 32'(duration), 32'd1);
    drive(1, 255, 32'h1234);
    check("end_finish", 32'(finish), 32'd1);
    check("end_error_num", 32'(error_num), 32'd0);
    check("end_duration", 32'(duration), 32'd1);

    // Wrong first answer keeps the monitor idle.
    pulse_reset(1);
    drive(1, 64, 5);
    idle(5);
    drive(1, 255, 0);
    drive(1, 66, 7);
    check("badfirst_state", 32'(dut.curstate), 32'd0);
    check("badfirst_finish", 32'(finish), 32'd0);
    drive(1, 64, 1);
    check("latestart_state", 32'(dut.curstate), 32'd1);

    // Mixed answers: 66 and 79 wrong.
    drive(1, 65, 4);
    drive(1, 66, 0);
    drive(1, 79, 99);
    drive(1, 70, 19);
    check("mixed_error_num", 32'(error_num), 32'd2);
    check("mixed_duration", 32'(duration), 32'd5);
    drive(0, 255, 0);
    drive(0, 66, 0);
    check("wen0_state", 32'(dut.curstate), 32'd1);
    check("wen0_error_num", 32'(error_num), 32'd2);
    drive(1, 255, 0);
    check("mixed_finish", 32'(finish), 32'd1);
    check("mixed_dur_frozen", 32'(duration), 32'd7);

    // DONE ignores everything.
    drive(1, 66, 0);
    drive(1, 255, 0);
    drive(1, 64, 1);
    idle(3);
    check("done_hold", {error_num, duration, 7'd0, finish}, {8'd2, 16'd7, 8'd1});
    check("done_state", 32'(dut.curstate), 32'd2);

    // Randomized traffic with occasional resets.
    pulse_reset(1);
    for (int i = 0; i < 4000; i++) begin
      int r, a, d;
      r = $urandom_range(0, 99);
      if (r < 55)      a = BASE + $urandom_range(0, NANS - 1);
      else if (r < 70) a = BASE;
      else if (r < 72) a = ENDA;
      else             a = $urandom_range(0, 1023);
      d = ($urandom_range(0, 1) == 1 && a >= BASE && a < BASE + NANS) ?
          gold(a - BASE) : $urandom_range(0, 60);
      if ($urandom_range(0, 399) == 0) pulse_reset(0);
      else drive($urandom_range(0, 9) < 7, a, d);
    end

    // Saturation of both counters, then async reset mid-CHECK.
    pulse_reset(1);
    drive(1, 64, 1);
    idle(70000);
    check("sat_duration", 32'(duration), 32'hFFFF);
    for (int i = 0; i < 300; i++) drive(1, 66, 0);
    check("sat_error_num", 32'(error_num), 32'd255);
    check("sat_state", 32'(dut.curstate), 32'd1);
    pulse_reset(1);
    idle(3);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
